// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared slot owner, queue entry type and width defaults for the framebuffer arbiter
package vga_fb_pkg;

  localparam int VGA_FB_ADDR_W = 20;
  localparam int VGA_FB_DATA_W = 30;

  // Who owns the RAM port in a given slot
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VID    = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } owner_e;

  // One queued CPU request, packed {we, addr, wdata}
  typedef struct packed {
    logic                     we;
    logic [VGA_FB_ADDR_W-1:0] addr;
    logic [VGA_FB_DATA_W-1:0] wdata;
  } fifo_entry_t;

endpackage

// File: rtl/vga_fb_req_fifo.sv
// rtl/vga_fb_req_fifo.sv - in-order synchronous request FIFO with level, full and empty
module vga_fb_req_fifo #(
  parameter int WIDTH = 51,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic [PTR_W:0]   level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign level_d = level_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Entry storage; contents are only meaningful below the level, so no reset
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; reset flushes the queue
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - video-priority framebuffer RAM arbiter with queued CPU port (optional VGA_FB_CPU_BYPASS_EN)
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W     = VGA_FB_ADDR_W,
  parameter int DATA_W     = VGA_FB_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STARVE = 1023
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  input  logic                        iVid_Req,
  input  logic [ADDR_W-1:0]           iVid_Addr,
  output logic                        oVid_Valid,
  output logic [DATA_W-1:0]           oVid_Data,
  input  logic                        iCpu_Valid,
  output logic                        oCpu_Ready,
  input  logic                        iCpu_We,
  input  logic [ADDR_W-1:0]           iCpu_Addr,
  input  logic [DATA_W-1:0]           iCpu_WData,
  output logic                        oCpu_RValid,
  output logic [DATA_W-1:0]           oCpu_RData,
  output logic [ADDR_W-1:0]           oMem_Addr,
  output logic [DATA_W-1:0]           oMem_WData,
  output logic                        oMem_We,
  input  logic [DATA_W-1:0]           iMem_RData,
  output logic [$clog2(FIFO_DEPTH):0] oFifo_Level,
  output logic                        oStarve
);

  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(MAX_STARVE + 1);

  logic               ready_en_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic               cpu_accept;
  logic               bypass;
  logic               push;
  logic               pop;
  owner_e             sel_owner;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  owner_e             owner_q;
  owner_e             tag_q;
  logic [CNT_W-1:0]   starve_cnt_q;
  logic [CNT_W-1:0]   starve_cnt_d;

  // Ready comes only from registered state, so a full queue never accepts even when popping
  assign oCpu_Ready = ready_en_q & ~fifo_full;
  assign cpu_accept = iCpu_Valid & oCpu_Ready;

`ifdef VGA_FB_CPU_BYPASS_EN
  assign bypass = cpu_accept & fifo_empty & ~iVid_Req;
`else
  assign bypass = 1'b0;
`endif

  assign push = cpu_accept & ~bypass;

  vga_fb_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i   (iCLK),
    .rst_ni  (iRST_N),
    .push_i  (push),
    .wdata_i ({iCpu_We, iCpu_Addr, iCpu_WData}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .level_o (oFifo_Level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Slot select: video first, then the queue head, then (optionally) a fresh request into an idle slot
  always_comb begin
    sel_owner = IDLE;
    sel_addr  = iVid_Addr;
    sel_wdata = '0;
    pop       = 1'b0;
    if (iVid_Req) begin
      sel_owner = VID;
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      sel_owner = fifo_head[ENTRY_W-1] ? CPU_WR : CPU_RD;
      sel_addr  = fifo_head[ADDR_W+DATA_W-1:DATA_W];
      sel_wdata = fifo_head[DATA_W-1:0];
    end else if (bypass) begin
      sel_owner = iCpu_We ? CPU_WR : CPU_RD;
      sel_addr  = iCpu_Addr;
      sel_wdata = iCpu_WData;
    end
  end

  // RAM port registers plus two owner tag stages; returning data is steered by the second tag
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      owner_q     <= IDLE;
      tag_q       <= IDLE;
      oMem_Addr   <= '0;
      oMem_WData  <= '0;
      oMem_We     <= 1'b0;
      oVid_Valid  <= 1'b0;
      oVid_Data   <= '0;
      oCpu_RValid <= 1'b0;
      oCpu_RData  <= '0;
    end else begin
      owner_q <= sel_owner;
      tag_q   <= owner_q;
      oMem_We <= (sel_owner == CPU_WR);
      if (sel_owner != IDLE)   oMem_Addr  <= sel_addr;
      if (sel_owner == CPU_WR) oMem_WData <= sel_wdata;
      oVid_Valid  <= (tag_q == VID);
      oCpu_RValid <= (tag_q == CPU_RD);
      if (tag_q == VID)    oVid_Data  <= iMem_RData;
      if (tag_q == CPU_RD) oCpu_RData <= iMem_RData;
    end
  end

  // Head wait counter: counts slots where a queued request was passed over, saturating
  always_comb begin
    starve_cnt_d = '0;
    if (!fifo_empty && !pop) begin
      starve_cnt_d = (starve_cnt_q == CNT_W'(MAX_STARVE)) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  // Sticky starvation flag and post-reset ready enable
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      starve_cnt_q <= '0;
      oStarve      <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      ready_en_q   <= 1'b1;
      if (starve_cnt_d == CNT_W'(MAX_STARVE)) oStarve <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard testbench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  localparam int AW = 20;
  localparam int DW = 30;
  localparam int FD = 4;
  localparam int MS = 8;
  localparam int LW = $clog2(FD) + 1;
`ifdef VGA_FB_CPU_BYPASS_EN
  localparam int CPU_LAT = 3;
`else
  localparam int CPU_LAT = 4;
`endif

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic          iVid_Req;
  logic [AW-1:0] iVid_Addr;
  logic          oVid_Valid;
  logic [DW-1:0] oVid_Data;
  logic          iCpu_Valid;
  logic          oCpu_Ready;
  logic          iCpu_We;
  logic [AW-1:0] iCpu_Addr;
  logic [DW-1:0] iCpu_WData;
  logic          oCpu_RValid;
  logic [DW-1:0] oCpu_RData;
  logic [AW-1:0] oMem_Addr;
  logic [DW-1:0] oMem_WData;
  logic          oMem_We;
  logic [DW-1:0] iMem_RData;
  logic [LW-1:0] oFifo_Level;
  logic          oStarve;

  vga_fb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD), .MAX_STARVE(MS)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iVid_Req(iVid_Req), .iVid_Addr(iVid_Addr),
    .oVid_Valid(oVid_Valid), .oVid_Data(oVid_Data),
    .iCpu_Valid(iCpu_Valid), .oCpu_Ready(oCpu_Ready), .iCpu_We(iCpu_We),
    .iCpu_Addr(iCpu_Addr), .iCpu_WData(iCpu_WData),
    .oCpu_RValid(oCpu_RValid), .oCpu_RData(oCpu_RData),
    .oMem_Addr(oMem_Addr), .oMem_WData(oMem_WData), .oMem_We(oMem_We),
    .iMem_RData(iMem_RData), .oFifo_Level(oFifo_Level), .oStarve(oStarve)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Framebuffer RAM model: one-cycle registered read, preloaded with data = addr
  logic          preload = 1'b1;
  logic [DW-1:0] ram [1024];
  always @(posedge iCLK) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= DW'(i);
    end else if (oMem_We === 1'b1) begin
      ram[oMem_Addr[9:0]] <= oMem_WData;
    end
    iMem_RData <= ram[oMem_Addr[9:0]];
  end

  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  logic [DW-1:0] ref_mem [1024];
  exp_t vid_q[$];
  exp_t rd_q[$];
  wr_t  wr_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   vid_seen = 0;
  int   rd_seen = 0;
  int   wr_seen = 0;

  task automatic sample();
    exp_t e;
    wr_t  w;
    if (oVid_Valid === 1'b1) begin
      vid_seen++;
      n_cmp++;
      if (vid_q.size() == 0) begin
        n_err++;
        $display("FAIL vid_unexpected: oVid_Valid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = vid_q.pop_front();
        if (oVid_Data !== e.data || cyc != e.cyc) begin
          n_err++;
          $display("FAIL vid_data: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d", oVid_Data, cyc, e.data, e.cyc);
        end
      end
    end
    if (oCpu_RValid === 1'b1) begin
      rd_seen++;
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL cpu_rd_unexpected: oCpu_RValid=1 at cycle %0d, required 0", cyc);
      end else begin
        e = rd_q.pop_front();
        if (oCpu_RData !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_err++;
          $display("FAIL cpu_rd_data: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d", oCpu_RData, cyc, e.data, e.cyc);
        end
      end
    end
    if (oMem_We === 1'b1) begin
      wr_seen++;
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_wr_unexpected: oMem_We=1 addr 0x%0h at cycle %0d, required 0", oMem_Addr, cyc);
      end else begin
        w = wr_q.pop_front();
        if (oMem_Addr !== w.addr || oMem_WData !== w.data) begin
          n_err++;
          $display("FAIL mem_wr: got addr 0x%0h data 0x%0h, required addr 0x%0h data 0x%0h", oMem_Addr, oMem_WData, w.addr, w.data);
        end
      end
    end
    if (iRST_N === 1'b1 && iVid_Req === 1'b1) begin
      e.data = ref_mem[iVid_Addr[9:0]];
      e.cyc  = cyc + 3;
      vid_q.push_back(e);
    end
  endtask

  // Advance one cycle: observe outputs mid-cycle, return to the drive point after the edge
  task automatic tick();
    @(negedge iCLK);
    sample();
    @(posedge iCLK);
    #1;
  endtask

  task automatic cpu_send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int lat, output int acc);
    int   waited;
    exp_t e;
    wr_t  w;
    waited = 0;
    acc = -1;
    iCpu_Valid = 1'b1; iCpu_We = we; iCpu_Addr = a; iCpu_WData = d;
    while (oCpu_Ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (oCpu_Ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL cpu_accept_timeout: ready=%b after %0d cycles, required 1", oCpu_Ready, waited);
      iCpu_Valid = 1'b0;
      return;
    end
    acc = cyc;
    if (we) begin
      ref_mem[a[9:0]] = d;
      w.addr = a; w.data = d;
      wr_q.push_back(w);
    end else begin
      e.data = ref_mem[a[9:0]];
      e.cyc  = (lat < 0) ? -1 : cyc + lat;
      rd_q.push_back(e);
    end
    tick();
    iCpu_Valid = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++;
    if ({oVid_Valid, oCpu_RValid, oMem_We, oCpu_Ready, oStarve, oFifo_Level,
         oMem_Addr, oMem_WData, oVid_Data, oCpu_RData} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b level=%0d we=%b addr=0x%0h starve=%b, required all 0",
               oCpu_Ready, oFifo_Level, oMem_We, oMem_Addr, oStarve);
    end
    iRST_N = 1'b1;
    tick();
    n_cmp++;
    if (oCpu_Ready !== 1'b1 || oFifo_Level !== '0) begin
      n_err++;
      $display("FAIL reset_release: ready=%b level=%0d, required ready=1 level=0", oCpu_Ready, oFifo_Level);
    end
  endtask

  task automatic test_video();
    int v0, w0;
    v0 = vid_seen; w0 = wr_seen;
    for (int i = 0; i < 640; i++) begin
      iVid_Req = 1'b1; iVid_Addr = AW'(i);
      tick();
    end
    iVid_Req = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (vid_seen - v0 != 640 || vid_q.size() != 0 || wr_seen != w0) begin
      n_err++;
      $display("FAIL video_run: valids=%0d pending=%0d writes=%0d, required 640/0/0",
               vid_seen - v0, vid_q.size(), wr_seen - w0);
    end
  endtask

  task automatic test_wr_rd();
    int acc, r0;
    r0 = rd_seen;
    cpu_send(1'b1, 20'h00100, 30'h0012345, -1, acc);
    cpu_send(1'b0, 20'h00100, '0, CPU_LAT, acc);
    repeat (8) tick();
    n_cmp++;
    if (rd_seen - r0 != 1 || rd_q.size() != 0 || wr_q.size() != 0) begin
      n_err++;
      $display("FAIL wr_then_rd: reads=%0d pending_rd=%0d pending_wr=%0d, required 1/0/0",
               rd_seen - r0, rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic       we_tab [8];
    logic [1:0] off_tab [8];
    int         acc, r0;
    we_tab  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    off_tab = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
    r0 = rd_seen;
    for (int k = 0; k < 8; k++) begin
      cpu_send(we_tab[k], 20'h00200 + AW'(off_tab[k]), DW'($urandom), CPU_LAT, acc);
    end
    repeat (8) tick();
    n_cmp++;
    if (rd_seen - r0 != 4 || rd_q.size() != 0 || wr_q.size() != 0) begin
      n_err++;
      $display("FAIL back_to_back: reads=%0d pending_rd=%0d pending_wr=%0d, required 4/0/0",
               rd_seen - r0, rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_cpu_latency();
    int acc;
    cpu_send(1'b0, 20'h00150, '0, CPU_LAT, acc);
`ifndef VGA_FB_CPU_BYPASS_EN
    tick();
`endif
    n_cmp++;
    if (oMem_Addr !== 20'h00150 || oMem_We !== 1'b0 || cyc != acc + CPU_LAT - 2) begin
      n_err++;
      $display("FAIL cpu_issue: addr=0x%0h we=%b at cycle %0d, required addr=0x150 we=0 at cycle %0d",
               oMem_Addr, oMem_We, cyc, acc + CPU_LAT - 2);
    end
    repeat (6) tick();
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_err++;
      $display("FAIL cpu_latency_drain: pending reads=%0d, required 0", rd_q.size());
    end
  endtask

  task automatic test_contention();
    int acc, accepted, we_cnt;
    wr_t w;
    iVid_Req = 1'b1; iVid_Addr = 20'h003A0;
    for (int k = 0; k < 4; k++) begin
      cpu_send(1'b1, 20'h00380 + AW'(k), DW'($urandom), -1, acc);
    end
    n_cmp++;
    if (oCpu_Ready !== 1'b0 || oFifo_Level !== LW'(4)) begin
      n_err++;
      $display("FAIL contention_full: ready=%b level=%0d, required ready=0 level=4", oCpu_Ready, oFifo_Level);
    end
    iCpu_Valid = 1'b1; iCpu_We = 1'b1; iCpu_Addr = 20'h00384; iCpu_WData = 30'h2ABCDEF;
    tick();
    iVid_Req = 1'b0;
    n_cmp++;
    if (oCpu_Ready !== 1'b0) begin
      n_err++;
      $display("FAIL contention_hold: ready=%b, required 0", oCpu_Ready);
    end
    accepted = 0; we_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (iCpu_Valid && oCpu_Ready === 1'b1) begin
        ref_mem[iCpu_Addr[9:0]] = iCpu_WData;
        w.addr = iCpu_Addr; w.data = iCpu_WData;
        wr_q.push_back(w);
        accepted = 1;
        tick();
        iCpu_Valid = 1'b0;
      end else begin
        tick();
      end
      if (oMem_We === 1'b1) we_cnt++;
    end
    n_cmp++;
    if (we_cnt != 4 || accepted != 1) begin
      n_err++;
      $display("FAIL contention_drain: writes in 4 cycles=%0d fifth_accepted=%0d, required 4/1", we_cnt, accepted);
    end
    iCpu_Valid = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (wr_q.size() != 0 || oStarve !== 1'b0) begin
      n_err++;
      $display("FAIL contention_end: pending writes=%0d starve=%b, required 0/0", wr_q.size(), oStarve);
    end
  endtask

  task automatic test_starvation();
    int acc;
    iVid_Req = 1'b1; iVid_Addr = 20'h003A1;
    cpu_send(1'b1, 20'h00390, 30'h1555555, -1, acc);
    while (cyc < acc + 8) tick();
    n_cmp++;
    if (oStarve !== 1'b0) begin
      n_err++;
      $display("FAIL starve_early: starve=%b at wait cycle 8, required 0", oStarve);
    end
    tick();
    n_cmp++;
    if (oStarve !== 1'b1) begin
      n_err++;
      $display("FAIL starve_set: starve=%b after 8 waiting cycles, required 1", oStarve);
    end
    while (cyc < acc + 20) tick();
    iVid_Req = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (oStarve !== 1'b1 || wr_q.size() != 0) begin
      n_err++;
      $display("FAIL starve_sticky: starve=%b pending writes=%0d, required 1/0", oStarve, wr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int acc, r0, v0;
    iVid_Req = 1'b1; iVid_Addr = 20'h003A2;
    for (int k = 0; k < 3; k++) cpu_send(1'b0, 20'h00210 + AW'(k), '0, -1, acc);
    n_cmp++;
    if (oFifo_Level !== LW'(3)) begin
      n_err++;
      $display("FAIL reset_mid_queued: level=%0d, required 3", oFifo_Level);
    end
    iRST_N = 1'b0; iVid_Req = 1'b0;
    tick();
    vid_q.delete();
    rd_q.delete();
    n_cmp++;
    if ({oVid_Valid, oCpu_RValid, oMem_We, oCpu_Ready, oStarve, oFifo_Level} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_hold: vvalid=%b rvalid=%b we=%b ready=%b starve=%b level=%0d, required all 0",
               oVid_Valid, oCpu_RValid, oMem_We, oCpu_Ready, oStarve, oFifo_Level);
    end
    iRST_N = 1'b1;
    tick();
    n_cmp++;
    if (oCpu_Ready !== 1'b1 || oFifo_Level !== '0) begin
      n_err++;
      $display("FAIL reset_mid_release: ready=%b level=%0d, required 1/0", oCpu_Ready, oFifo_Level);
    end
    r0 = rd_seen; v0 = vid_seen;
    repeat (10) tick();
    n_cmp++;
    if (rd_seen != r0 || vid_seen != v0) begin
      n_err++;
      $display("FAIL reset_mid_flush: reads=%0d video=%0d after reset, required 0/0", rd_seen - r0, vid_seen - v0);
    end
  endtask

  initial begin
    iRST_N = 1'b0; iVid_Req = 1'b0; iVid_Addr = '0;
    iCpu_Valid = 1'b0; iCpu_We = 1'b0; iCpu_Addr = '0; iCpu_WData = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = DW'(i);
    @(posedge iCLK);
    #1;
    preload = 1'b0;
    test_reset();
    test_video();
    test_wr_rd();
    test_back_to_back();
    test_cpu_latency();
    test_contention();
    test_starvation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between two requesters: the VGA scan-out path, which issues one pixel read per active pixel clock, and the MIPS CPU bus, which issues reads and writes through a valid/ready handshake. Video always has priority. CPU accesses are queued in a small in-order FIFO and drain during blanking or idle slots. The block sits between the VGA controller's pixel address/enable outputs and the framebuffer RAM.

Parameters:
ADDR_W, 20, framebuffer word address width (640x480 = 307200 words)
DATA_W, 30, pixel word width (10-bit R, G, B packed R[29:20], G[19:10], B[9:0])
FIFO_DEPTH, 4, CPU request FIFO entries (power of two, >= 2)
MAX_STARVE, 1023, cycles the FIFO head may wait before the starvation flag is set

Ports:
iCLK  in  1  pixel clock (25.175 MHz)
iRST_N  in  1  synchronous active-low reset
iVid_Req  in  1  video read request, driven by the scan enable
iVid_Addr  in  ADDR_W  video read address
oVid_Valid  out  1  video read data valid
oVid_Data  out  DATA_W  video read data
iCpu_Valid  in  1  CPU request valid
oCpu_Ready  out  1  CPU request accepted when high together with iCpu_Valid
iCpu_We  in  1  1 = write, 0 = read
iCpu_Addr  in  ADDR_W  CPU address
iCpu_WData  in  DATA_W  CPU write data
oCpu_RValid  out  1  CPU read data valid, one-cycle pulse
oCpu_RData  out  DATA_W  CPU read data
oMem_Addr  out  ADDR_W  RAM address, registered
oMem_WData  out  DATA_W  RAM write data, registered
oMem_We  out  1  RAM write enable, registered
iMem_RData  in  DATA_W  RAM read data, valid 1 cycle after oMem_Addr
oFifo_Level  out  log2(FIFO_DEPTH)+1  current CPU FIFO occupancy
oStarve  out  1  sticky starvation flag

Behaviour:
- Reset (iRST_N low at a clock edge): FIFO is flushed, slot pipeline is cleared, and every output goes to 0, except oCpu_Ready, which is 1 from the first cycle after reset release. Reset during operation drops queued and in-flight requests, and produces no oVid_Valid or oCpu_RValid for them.
- Slot select, every cycle, with owner state in {IDLE, VID, CPU_RD, CPU_WR}:
  - iVid_Req = 1 -> VID.
  - Otherwise, FIFO non-empty -> CPU_RD or CPU_WR according to the head entry's we bit, and the head is popped.
  - Otherwise -> IDLE.
- The owner and the source address, data and we are registered onto oMem_* at the next edge. oMem_We = 1 only for CPU_WR.
- Tag pipeline: the owner is delayed two stages alongside the RAM.
  - Video latency is fixed at 3 cycles: iVid_Req at cycle N -> oVid_Valid = 1 with the data at N+3.
  - CPU read: oCpu_RValid fires 3 cycles after the slot that popped the entry.
- oCpu_Ready = (level < FIFO_DEPTH), taken from the registered level. A pop and a push in the same cycle while the FIFO is full still deasserts ready (no pass-through). A push into an empty FIFO is not eligible until the next cycle (no bypass).
- Ordering: CPU requests complete in acceptance order. A read issued after a write to the same address returns the new data.
- Starvation counter: increments each cycle the FIFO is non-empty and the head is not popped. It resets to 0 on a pop or when the FIFO becomes empty. It saturates at MAX_STARVE, and on reaching MAX_STARVE it sets oStarve, which is cleared only by reset. Video is never preempted.
- Address and data pass through unmodified; there is no address arithmetic.

Optional Feature:
VGA_FB_CPU_BYPASS_EN:
- Defined: when the FIFO is empty, iVid_Req = 0 and a CPU request is accepted, that request takes the same-cycle slot directly. CPU read latency drops to 3 cycles from acceptance.
- Undefined: the request always passes through the FIFO, so the minimum CPU latency is 4 cycles. The oStarve and ordering rules are unchanged in both cases.

Decomposition:
- Shared package vga_fb_pkg: slot owner enum (IDLE, VID, CPU_RD, CPU_WR), FIFO entry struct {we, addr, wdata}, and the ADDR_W / DATA_W defaults.
- One sub-module: vga_fb_req_fifo, a synchronous FIFO with push, pop, level, full and empty, reused for the CPU queue.

Test Plan:
- Video only: iVid_Req = 1 for 640 cycles with addresses 0..639 from a RAM preloaded with data = addr -> oVid_Valid for 640 cycles starting at cycle 3, oVid_Data = 0..639 in order, oMem_We never 1.
- CPU write then read during blanking: write 0x12345 to addr 0x100, then read 0x100 -> oCpu_RValid once with oCpu_RData = 0x12345, 4 cycles after the read is accepted.
- Contention: iVid_Req held at 1 while the CPU pushes 5 writes -> first 4 accepted, oCpu_Ready = 0, oFifo_Level = 4; after iVid_Req drops, one oMem_We per cycle for 4 cycles, then the 5th write is accepted.
- Starvation: MAX_STARVE = 8, one CPU write queued, iVid_Req held at 1 for 20 cycles -> oStarve rises after the 8th waiting cycle and stays 1 after the write drains.
- Reset mid-operation: 3 CPU reads queued plus video in flight, pulse iRST_N low for 1 cycle -> no oVid_Valid or oCpu_RValid afterwards, oFifo_Level = 0, oCpu_Ready = 1 on the first cycle after release.
- Bypass (VGA_FB_CPU_BYPASS_EN defined): idle bus, single CPU read -> oMem_Addr equals the read address 1 cycle after acceptance, oCpu_RValid 3 cycles after acceptance.
